// File: rtl/adc_frame_packer.sv
// Captures a frame of N_SAMPLES ADC samples (optionally decimated) into a wide
// register and holds it until the downstream packer acknowledges it.
module adc_frame_packer #(
    parameter int SAMPLE_W  = 16,
    parameter int N_SAMPLES = 512,
    parameter int DECIM     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [SAMPLE_W-1:0]           adc_din,
    input  logic                          adc_din_vld,
    input  logic                          frame_ack,
    output logic [SAMPLE_W*N_SAMPLES-1:0] ADC_data,
    output logic                          valid,
    output logic                          overflow,
    output logic [15:0]                   drop_cnt,
    output logic                          busy
);

    localparam int IDX_W  = $clog2(N_SAMPLES);
    localparam int DCNT_W = 8;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SAMPLES - 1);
    localparam logic [DCNT_W-1:0] LAST_DCNT = DCNT_W'(DECIM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                overflow_q, overflow_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                store;
    logic [SAMPLE_W-1:0] slot_q [N_SAMPLES];

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DCNT_W-1:0] dcnt_next(input logic [DCNT_W-1:0] v);
        return (v == LAST_DCNT) ? '0 : v + 1'b1;
    endfunction

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dcnt_d     = dcnt_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        store      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FILL;
                    idx_d   = '0;
                    dcnt_d  = '0;
                end
            end
            FILL: begin
                // Losing start abandons the partial frame; a strobe in that cycle is not kept.
                if (!start) begin
                    state_d = IDLE;
                end else if (adc_din_vld) begin
                    dcnt_d = dcnt_next(dcnt_q);
                    if (dcnt_q == '0) begin
                        store = 1'b1;
                        if (idx_q == LAST_IDX) begin
                            state_d = HOLD;
                            idx_d   = '0;
                            dcnt_d  = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (adc_din_vld) begin
                    overflow_d = 1'b1;
                    drop_cnt_d = sat_inc16(drop_cnt_q);
                end
                if (frame_ack) begin
                    state_d = start ? FILL : IDLE;
                    idx_d   = '0;
                    dcnt_d  = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            dcnt_q     <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dcnt_q     <= dcnt_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // One write-enabled register per slot; only the addressed slot changes.
    for (genvar k = 0; k < N_SAMPLES; k++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst) begin
                slot_q[k] <= '0;
            end else if (store && (idx_q == IDX_W'(k))) begin
                slot_q[k] <= adc_din;
            end
        end
        assign ADC_data[k*SAMPLE_W +: SAMPLE_W] = slot_q[k];
    end

    assign valid    = (state_q == HOLD);
    assign busy     = (state_q == FILL);
    assign overflow = overflow_q;
    assign drop_cnt = drop_cnt_q;

endmodule
